// File: rtl/apb_uart_tx_master.sv
// APB initiator for a 16550-style UART: programs divisor and line format after reset, then polls LSR.THRE and writes each accepted byte to THR.
// Defining APB_UART_TX_MASTER_CRLF_EN makes an accepted LF go out as CR then LF.
module apb_uart_tx_master #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [15:0] DIVISOR    = 16'd27,
    parameter logic [7:0]  LCR_VAL    = 8'h03,
    parameter int unsigned POLL_LIMIT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        init_done,
    output logic        err,
    output logic [31:0] PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);
    localparam int unsigned CW = $clog2(POLL_LIMIT + 1);
    localparam logic [2:0] REG_THR = 3'd0;
    localparam logic [2:0] REG_LSR = 3'd5;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_POLL, ST_WRITE} state_t;

    state_t        state_q;
    logic [2:0]    step_q;
    logic [CW-1:0] poll_cnt_q;
    logic [7:0]    byte_q;
    logic          psel_q, penable_q, pwrite_q;
    logic [31:0]   paddr_q, pwdata_q;
    logic          tx_ready_q, init_done_q, err_q;
`ifdef APB_UART_TX_MASTER_CRLF_EN
    logic          lf_pend_q;
`endif

    logic       xfer_done;
    logic [2:0] init_reg;
    logic [7:0] init_val;
    logic       unused_prdata;

    assign xfer_done     = psel_q & penable_q & PREADY;
    assign unused_prdata = ^{PRDATA[31:6], PRDATA[4:0]};

    function automatic logic [31:0] reg_addr(input logic [2:0] idx);
        return BASE_ADDR + {27'd0, idx, 2'b00};
    endfunction

    // Step 0 opens the divisor latch; step 3 closes it with the final line format.
    always_comb begin
        init_reg = 3'd3;
        init_val = 8'h80;
        case (step_q)
            3'd0: begin init_reg = 3'd3; init_val = 8'h80;              end
            3'd1: begin init_reg = 3'd0; init_val = DIVISOR[7:0];       end
            3'd2: begin init_reg = 3'd1; init_val = DIVISOR[15:8];      end
            3'd3: begin init_reg = 3'd3; init_val = LCR_VAL & 8'h7F;    end
            3'd4: begin init_reg = 3'd2; init_val = 8'h07;              end
            default: begin init_reg = 3'd1; init_val = 8'h00;           end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_INIT;
            step_q      <= '0;
            poll_cnt_q  <= '0;
            byte_q      <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            tx_ready_q  <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef APB_UART_TX_MASTER_CRLF_EN
            lf_pend_q   <= 1'b0;
`endif
        end else begin
            if (psel_q && !penable_q) begin
                penable_q <= 1'b1;
            end
            if (xfer_done) begin
                psel_q    <= 1'b0;
                penable_q <= 1'b0;
                if (PSLVERR) begin
                    err_q <= 1'b1;
                end
            end

            case (state_q)
                ST_INIT: begin
                    if (!psel_q) begin
                        psel_q   <= 1'b1;
                        pwrite_q <= 1'b1;
                        paddr_q  <= reg_addr(init_reg);
                        pwdata_q <= {24'd0, init_val};
                    end else if (xfer_done) begin
                        if (step_q == 3'd5) begin
                            state_q     <= ST_IDLE;
                            init_done_q <= 1'b1;
                            tx_ready_q  <= 1'b1;
                        end else begin
                            step_q <= step_q + 3'd1;
                        end
                    end
                end
                ST_IDLE: begin
                    // The LSR read is launched on the accept edge itself to save a cycle.
                    if (tx_valid && tx_ready_q) begin
                        tx_ready_q <= 1'b0;
                        state_q    <= ST_POLL;
`ifdef APB_UART_TX_MASTER_CRLF_EN
                        byte_q     <= (tx_data == 8'h0A) ? 8'h0D : tx_data;
                        lf_pend_q  <= (tx_data == 8'h0A);
`else
                        byte_q     <= tx_data;
`endif
                        psel_q     <= 1'b1;
                        pwrite_q   <= 1'b0;
                        paddr_q    <= reg_addr(REG_LSR);
                        pwdata_q   <= '0;
                    end
                end
                ST_POLL: begin
                    if (!psel_q) begin
                        psel_q   <= 1'b1;
                        pwrite_q <= 1'b0;
                        paddr_q  <= reg_addr(REG_LSR);
                        pwdata_q <= '0;
                    end else if (xfer_done) begin
                        if (PRDATA[5]) begin
                            poll_cnt_q <= '0;
                            state_q    <= ST_WRITE;
                        end else if (poll_cnt_q != CW'(POLL_LIMIT)) begin
                            poll_cnt_q <= poll_cnt_q + CW'(1);
                            if (poll_cnt_q == CW'(POLL_LIMIT - 1)) begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (!psel_q) begin
                        psel_q   <= 1'b1;
                        pwrite_q <= 1'b1;
                        paddr_q  <= reg_addr(REG_THR);
                        pwdata_q <= {24'd0, byte_q};
                    end else if (xfer_done) begin
`ifdef APB_UART_TX_MASTER_CRLF_EN
                        if (lf_pend_q) begin
                            byte_q    <= 8'h0A;
                            lf_pend_q <= 1'b0;
                            state_q   <= ST_POLL;
                        end else begin
                            state_q    <= ST_IDLE;
                            tx_ready_q <= 1'b1;
                        end
`else
                        state_q    <= ST_IDLE;
                        tx_ready_q <= 1'b1;
`endif
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign tx_ready  = tx_ready_q;
    assign init_done = init_done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_apb_uart_tx_master.sv
// Randomised bench for apb_uart_tx_master: APB slave model with wait states and THRE control, scoreboard of expected APB transfers.
module tb_apb_uart_tx_master;
    localparam int POLL_LIMIT = 16;
    localparam logic [31:0] A_THR = 32'h00;
    localparam logic [31:0] A_LSR = 32'h14;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready, init_done, err;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } xact_t;

    xact_t       exp_q[$];
    xact_t       e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          wait_cfg = 0;
    int          wait_cnt = 0;
    int          busy_left = 0;
    int          consec = 0;
    bit          pslverr_next = 1'b0;
    bit          exp_err = 1'b0;
    bit          prev_psel = 1'b0;
    logic [31:0] s_addr, s_data, rd_word;
    logic        s_wr;

    apb_uart_tx_master dut (
        .CLK(CLK), .RST(RST),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .init_done(init_done), .err(err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_w(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back('{addr: a, wr: 1'b1, data: d});
    endtask

    task automatic push_r(input logic [31:0] a);
        exp_q.push_back('{addr: a, wr: 1'b0, data: 32'h0});
    endtask

    // Default parameters: divisor 27, LCR 0x03.
    task automatic push_init();
        push_w(32'h0C, 32'h80);
        push_w(32'h00, 32'h1B);
        push_w(32'h04, 32'h00);
        push_w(32'h0C, 32'h03);
        push_w(32'h08, 32'h07);
        push_w(32'h04, 32'h00);
    endtask

    task automatic wait_init();
        for (int i = 0; i < 300 && !init_done; i++) @(negedge CLK);
        chk("init_done", 32'(init_done), 32'd1);
        chk("init_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int busy, input int ws);
        logic [7:0] outs[$];
        outs = {b};
`ifdef APB_UART_TX_MASTER_CRLF_EN
        if (b == 8'h0A) outs = {8'h0D, 8'h0A};
`endif
        wait_cfg  = ws;
        busy_left = busy;
        foreach (outs[k]) begin
            if (k == 0) begin
                for (int p = 0; p < busy; p++) push_r(A_LSR);
            end
            push_r(A_LSR);
            push_w(A_THR, {24'd0, outs[k]});
        end
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 50 && !tx_ready; i++) @(negedge CLK);
        chk("tx_ready_idle", 32'(tx_ready), 32'd1);
        @(negedge CLK);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        chk("tx_ready_after_accept", 32'(tx_ready), 32'd0);
        for (int i = 0; i < 150 + busy * 10 && !tx_ready; i++) @(negedge CLK);
        chk("tx_ready_return", 32'(tx_ready), 32'd1);
        chk("byte_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // APB slave, protocol checker and scoreboard monitor.
    always @(negedge CLK) begin
        if (RST) begin
            exp_err  = 1'b0;
            consec   = 0;
            PREADY   = 1'b0;
            PSLVERR  = 1'b0;
            wait_cnt = 0;
        end else begin
            chk("err_flag", 32'(err), 32'(exp_err));
            if (!init_done) chk("tx_ready_before_init", 32'(tx_ready), 32'd0);
            if (PSEL && !PENABLE) begin
                chk("psel_gap", 32'(prev_psel), 32'd0);
                s_addr = PADDR;
                s_data = PWDATA;
                s_wr   = PWRITE;
            end else if (PSEL && PENABLE) begin
                chk("access_addr_stable", PADDR, s_addr);
                chk("access_data_stable", PWDATA, s_data);
                chk("access_write_stable", 32'(PWRITE), 32'(s_wr));
                if (wait_cnt < wait_cfg) begin
                    PREADY = 1'b0;
                    wait_cnt++;
                end else begin
                    PREADY  = 1'b1;
                    PSLVERR = pslverr_next;
                    if (pslverr_next) begin
                        exp_err      = 1'b1;
                        pslverr_next = 1'b0;
                    end
                    rd_word = $urandom;
                    if (!PWRITE && PADDR == A_LSR) begin
                        if (busy_left > 0) begin
                            busy_left--;
                            consec++;
                            rd_word[5] = 1'b0;
                            if (consec == POLL_LIMIT) exp_err = 1'b1;
                        end else begin
                            rd_word[5] = 1'b1;
                            consec = 0;
                        end
                    end
                    PRDATA = rd_word;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_xfer: got addr %h write %0d data %h, expected no transfer",
                                 PADDR, PWRITE, PWDATA);
                    end else begin
                        e = exp_q.pop_front();
                        chk("apb_addr", PADDR, e.addr);
                        chk("apb_write", 32'(PWRITE), 32'(e.wr));
                        if (e.wr) chk("apb_wdata", PWDATA, e.data);
                    end
                end
            end else begin
                PREADY   = 1'b0;
                PSLVERR  = 1'b0;
                wait_cnt = 0;
            end
        end
        prev_psel = PSEL;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        RST      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        PRDATA   = 32'h0;
        PREADY   = 1'b0;
        PSLVERR  = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        push_init();
        RST = 1'b0;
        wait_init();
        chk("init_err", 32'(err), 32'd0);

        send_byte(8'h41, 0, 0);
        send_byte(8'($urandom), 0, 3);
        for (int n = 0; n < 8; n++) begin
            send_byte(8'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
        end
        send_byte(8'h0A, 0, 0);
        send_byte(8'h42, 0, 1);
        chk("err_before_busy", 32'(err), 32'd0);

        send_byte(8'($urandom), 20, 0);
        chk("err_after_poll_limit", 32'(err), 32'd1);
        send_byte(8'h41, 0, 0);
        chk("err_sticky", 32'(err), 32'd1);

        // Reset in the ACCESS phase of the DLM write.
        RST = 1'b1;
        @(negedge CLK);
        exp_q.delete();
        push_init();
        wait_cfg = 5;
        RST = 1'b0;
        for (int i = 0; i < 200 && !(PSEL && PENABLE && PADDR == 32'h04); i++) @(negedge CLK);
        chk("step3_addr", PADDR, 32'h04);
        chk("step3_access", 32'(PENABLE), 32'd1);
        RST = 1'b1;
        exp_q.delete();
        @(negedge CLK);
        chk("midreset_psel", 32'(PSEL), 32'd0);
        chk("midreset_penable", 32'(PENABLE), 32'd0);
        chk("midreset_init_done", 32'(init_done), 32'd0);
        wait_cfg = 0;
        push_init();
        RST = 1'b0;
        wait_init();
        chk("err_cleared_by_reset", 32'(err), 32'd0);

        pslverr_next = 1'b1;
        send_byte(8'h55, 0, 0);
        chk("err_after_pslverr", 32'(err), 32'd1);

        repeat (5) @(negedge CLK);
        chk("queue_empty_end", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/apb_uart_tx_master.md
Name: apb_uart_tx_master

Overview:
- APB initiator that drives a 16550-compatible UART APB slave: programs baud divisor and line format after reset, then streams bytes from a valid/ready source into THR.
- Polls LSR.THRE before every THR write.
- Sits between console or boot-message logic and the UART APB port, in the FPGA top and in the testbench.

Parameters:
- BASE_ADDR, 32'h0000_0000, APB base address of the UART; register n is at BASE_ADDR + (n << 2).
- DIVISOR, 16'd27, baud divisor; DLL gets bits [7:0], DLM gets bits [15:8].
- LCR_VAL, 8'h03, line-control value after init (8N1, DLAB clear).
- POLL_LIMIT, 16, consecutive LSR reads with THRE=0 before err is set; must be >= 1.

Ports:
- CLK  in  1  clock; all logic on its rising edge
- RST  in  1  synchronous reset, active-high
- tx_data  in  8  byte to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  byte accepted when tx_valid & tx_ready
- init_done  out  1  high once the init sequence completes; stays high until RST
- err  out  1  sticky error: PSLVERR seen or poll limit reached; cleared only by RST
- PADDR  out  32  APB address
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB write
- PWDATA  out  32  APB write data; bits [31:8] always 0
- PRDATA  in  32  APB read data; only [7:0] used
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

Behaviour:
- Reset values (RST sampled high on a clock edge): PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, tx_ready=0, init_done=0, err=0, state=INIT, init step=0, poll count=0, byte buffer cleared.
- A reset mid-transfer drops PSEL/PENABLE on the next edge without waiting for PREADY; init restarts from step 0.
- APB transfer timing:
  - SETUP: one cycle, PSEL=1, PENABLE=0, address/data/PWRITE stable.
  - ACCESS: PENABLE=1, held until PREADY=1.
  - The transfer completes on the edge where PENABLE & PREADY.
  - PSEL returns to 0 for at least one cycle between transfers; no back-to-back pipelining.
  - PRDATA is captured at completion.
  - PSLVERR at completion sets err; the sequence continues as if the transfer succeeded.
- Init sequence, all writes, in order:
  1. LCR(3) = 8'h80
  2. DLL(0) = DIVISOR[7:0]
  3. DLM(1) = DIVISOR[15:8]
  4. LCR(3) = LCR_VAL & 8'h7F
  5. FCR(2) = 8'h07
  6. IER(1) = 8'h00
  - init_done rises the cycle after the sixth write completes.
- States:
  - INIT: issue init writes; go to IDLE after the last.
  - IDLE: tx_ready=1. On tx_valid, latch tx_data, drop tx_ready next cycle, go to POLL.
  - POLL: read LSR(5).
    - PRDATA[5]=1: go to WRITE and clear the poll count.
    - Else: increment the poll count (saturating), set err when it reaches POLL_LIMIT, re-poll; err does not stop polling.
  - WRITE: write the latched byte to THR(0); on completion return to IDLE.
- tx_ready is 1 only in IDLE with init_done=1; exactly one byte is accepted per handshake.
- tx_data/tx_valid are ignored outside IDLE.
- Minimum latency from accept to THR write completion, with zero-wait slave and THRE=1: 5 cycles (accept, 2 for LSR read, 2 for THR write).

Optional Feature:
- Macro: APB_UART_TX_MASTER_CRLF_EN.
- Defined:
  - An accepted 8'h0A is sent as 8'h0D then 8'h0A; each byte gets its own LSR poll and THR write.
  - tx_ready stays low until both are written.
  - Other bytes are unchanged.
- Undefined: bytes are passed through verbatim; no CR insertion logic is synthesised.

Test Plan:
- Reset, zero-wait slave:
  - Required APB writes in order: (0x0C,0x80), (0x00,0x1B), (0x04,0x00), (0x0C,0x03), (0x08,0x07), (0x04,0x00).
  - init_done rises after the sixth write; err=0.
- Send 8'h41 with THRE=1:
  - LSR read at 0x14, then write 0x00 with PWDATA=0x41.
  - tx_ready low from the cycle after accept until return to IDLE.
- Slave holds PREADY=0 for 3 cycles on the THR write:
  - PENABLE, PADDR and PWDATA stay stable for all 4 ACCESS cycles.
  - Exactly one write is issued.
- THRE=0 for 20 polls, then THRE=1:
  - err set after the 16th poll.
  - Byte still written after THRE rises.
  - err stays 1 until RST.
- Assert RST during the ACCESS phase of init step 3:
  - PSEL=0 on the next edge.
  - Init restarts with LCR=0x80.
- With APB_UART_TX_MASTER_CRLF_EN, send 8'h0A:
  - THR writes are 0x0D then 0x0A.
  - Sending 8'h42 yields a single write of 0x42.
